// File: rtl/if_fetch_buf_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
// Holds the fetch FSM state codes and the pipeline-control encodings it reuses.
package if_fetch_buf_pkg;

  localparam int INST_ADDR_W  = 32;
  localparam int INST_W       = 32;
  localparam int STALL_W      = 6;
  localparam int STALL_ID_BIT = 1;

  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic BRANCH      = 1'b1;
  localparam logic NO_STOP     = 1'b0;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

  // Occupancy counter must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_fetch_buf_if.sv
// Instruction-memory read port: single outstanding req/ack handshake.
interface if_fetch_buf_if
  import if_fetch_buf_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_W
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/if_fetch_buf_inst_fifo.sv
// DEPTH-entry instruction FIFO with flush; the head is presented combinationally
// from registered storage and reads as zero (NOP) when empty.
module if_fetch_buf_inst_fifo
  import if_fetch_buf_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_W,
  parameter int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [DATA_W-1:0] push_inst_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [DATA_W-1:0] head_inst_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; valid_o gates stale contents off the outputs.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      pc_mem[wr_ptr_q]   <= push_pc_i;
      inst_mem[wr_ptr_q] <= push_inst_i;
    end
  end

  // When full, a simultaneous push rewrites the slot being popped, so it becomes the tail.
  assign count_o     = count_q;
  assign valid_o     = (count_q != '0);
  assign head_pc_o   = valid_o ? pc_mem[rd_ptr_q]   : '0;
  assign head_inst_o = valid_o ? inst_mem[rd_ptr_q] : '0;

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage: one outstanding imem read at a time, results queued
// for decode, with a stall request while the current PC is not yet captured.
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               ce,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  if_fetch_buf_if.master     imem,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [DATA_W-1:0]  id_inst,
  output logic               stallreq_if
);

  localparam int CNT_W = cnt_w(DEPTH);

  fetch_state_e      state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count;

  logic ack, redirect, fetching, decode_free, has_room, push, pop;
  logic unused_stall;

  assign ack         = imem.imem_ack;
  assign redirect    = (branch_flag_i == BRANCH);
  assign fetching    = (ce == CHIP_ENABLE);
  assign decode_free = (stall[STALL_ID_BIT] == NO_STOP);
  assign has_room    = (count < CNT_W'(DEPTH));
  assign unused_stall = ^{stall[STALL_W-1:STALL_ID_BIT+1], stall[STALL_ID_BIT-1:0]};

  // A redirect overrides both ends of the queue: nothing enters, nothing leaves, all is flushed.
  assign push = (state_q == FETCH_WAIT) && ack && !redirect;
  assign pop  = id_valid && decode_free && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (fetching && has_room && !redirect) begin
            req_q   <= 1'b1;
            addr_q  <= pc;
            state_q <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (ack) begin
            req_q   <= 1'b0;
            state_q <= FETCH_IDLE;
          end else if (redirect) begin
            state_q <= FETCH_DISCARD;
          end
        end
        FETCH_DISCARD: begin
          // The memory still owes a response; keep the request up and drop the data.
          if (ack) begin
            req_q   <= 1'b0;
            state_q <= FETCH_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= FETCH_IDLE;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  // The PC may advance only on the edge that captures its instruction.
  assign stallreq_if = fetching && !redirect && !((state_q == FETCH_WAIT) && ack);

  if_fetch_buf_inst_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_inst_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (redirect),
    .push_pc_i   (addr_q),
    .push_inst_i (imem.imem_rdata),
    .count_o     (count),
    .valid_o     (id_valid),
    .head_pc_o   (id_pc),
    .head_inst_o (id_inst)
  );

endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based model of the fetch buffer's observable behaviour.
module tb_if_fetch_buf;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        stallreq_if;

  int checks = 0;
  int errors = 0;

  if_fetch_buf_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();

  if_fetch_buf #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .ce            (ce),
    .stall         (stall),
    .branch_flag_i (branch_flag_i),
    .imem          (imem_bus),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .stallreq_if   (stallreq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instructions waiting for decode, plus the one outstanding read.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      mq[$];
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [31:0] pc_reg;

  task automatic model_reset();
    mq.delete();
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_addr = '0;
    pc_reg = '0;
  endtask

  // One clock cycle: drive after the falling edge, compare, then advance the model at the rising edge.
  task automatic cycle(input bit c, input bit st1, input bit br, input logic [31:0] tgt,
                       input bit ack_v, input logic [31:0] rd);
    bit exp_stallreq;
    bit was_out;
    int sz;
    @(negedge clk);
    ce                  = c;
    pc                  = pc_reg;
    stall               = 6'($urandom);
    stall[1]            = st1;
    branch_flag_i       = br;
    imem_bus.imem_ack   = ack_v;
    imem_bus.imem_rdata = rd;
    #1;
    exp_stallreq = c && !br && !(m_out && !m_drop && ack_v);
    checks++;
    if (id_valid !== (mq.size() != 0)) begin
      errors++;
      $display("FAIL id_valid: got %b expected %b", id_valid, mq.size() != 0);
    end
    checks++;
    if (mq.size() != 0) begin
      if (id_pc !== mq[0].pc || id_inst !== mq[0].inst) begin
        errors++;
        $display("FAIL head: got pc=%h inst=%h expected pc=%h inst=%h", id_pc, id_inst, mq[0].pc, mq[0].inst);
      end
    end else if (id_pc !== 32'h0 || id_inst !== 32'h0) begin
      errors++;
      $display("FAIL empty_head: got pc=%h inst=%h expected 0/0", id_pc, id_inst);
    end
    checks++;
    if (imem_bus.imem_req !== m_out) begin
      errors++;
      $display("FAIL imem_req: got %b expected %b", imem_bus.imem_req, m_out);
    end
    if (m_out) begin
      checks++;
      if (imem_bus.imem_addr !== m_addr) begin
        errors++;
        $display("FAIL imem_addr: got %h expected %h", imem_bus.imem_addr, m_addr);
      end
    end
    checks++;
    if (stallreq_if !== exp_stallreq) begin
      errors++;
      $display("FAIL stallreq_if: got %b expected %b", stallreq_if, exp_stallreq);
    end
    @(posedge clk);
    was_out = m_out;
    sz      = mq.size();
    if (br) mq.delete();
    else begin
      if (sz > 0 && !st1) void'(mq.pop_front());
      if (was_out && ack_v && !m_drop) mq.push_back('{m_addr, rd});
    end
    if (was_out && ack_v) begin
      m_out  = 1'b0;
      m_drop = 1'b0;
    end else if (was_out && br) begin
      m_drop = 1'b1;
    end
    if (!was_out && c && sz < DEPTH && !br) begin
      m_out  = 1'b1;
      m_addr = pc_reg;
    end
    if (br) pc_reg = tgt;
    else if (c && !exp_stallreq) pc_reg = pc_reg + 32'd4;
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h0 || id_valid !== 1'b0 ||
        id_pc !== 32'h0 || id_inst !== 32'h0 || stallreq_if !== 1'b0) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h inst=%h stallreq=%b expected all 0",
               tag, imem_bus.imem_req, imem_bus.imem_addr, id_valid, id_pc, id_inst, stallreq_if);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; pc = '0; stall = '0; branch_flag_i = 1'b0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    #2 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_values");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_latency();
    pc_reg = 32'h0;
    cycle(1, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL latency_req: got req=%b addr=%h expected 1/0", imem_bus.imem_req, imem_bus.imem_addr);
    end
    cycle(1, 0, 0, 0, 1, 32'h3C01_0001);
    #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'h3C01_0001) begin
      errors++;
      $display("FAIL latency_data: got valid=%b pc=%h inst=%h expected 1/0/3c010001", id_valid, id_pc, id_inst);
    end
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_delayed_ack();
    pc_reg = 32'h100;
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h100 || stallreq_if !== 1'b1) begin
        errors++;
        $display("FAIL delayed_hold: got req=%b addr=%h stallreq=%b expected 1/100/1",
                 imem_bus.imem_req, imem_bus.imem_addr, stallreq_if);
      end
    end
    cycle(1, 0, 0, 0, 1, 32'hDEAD_0100);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall_fill();
    bit seen;
    pc_reg = 32'h0;
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, m_out, $urandom);
    #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_bus.imem_req !== 1'b0 || stallreq_if !== 1'b1) begin
      errors++;
      $display("FAIL stall_full: got valid=%b pc=%h req=%b stallreq=%b expected 1/0/0/1",
               id_valid, id_pc, imem_bus.imem_req, stallreq_if);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1, 0, 0, 0, 1'b0, 0);
      #1;
      if (imem_bus.imem_req === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (imem_bus.imem_addr !== 32'h8) begin
          errors++;
          $display("FAIL stall_resume: got addr=%h expected 00000008", imem_bus.imem_addr);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL stall_resume_timeout: got no request expected request to 00000008");
    end
    cycle(0, 0, 0, 0, 1, $urandom);
    repeat (4) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_branch();
    pc_reg = 32'h200;
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 32'hAAAA_0200);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 32'h1000, 0, 0);
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL branch_flush: got valid=%b req=%b expected 0/1", id_valid, imem_bus.imem_req);
    end
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 32'hBBBB_0204);
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL branch_drop: got valid=%b req=%b expected 0/0", id_valid, imem_bus.imem_req);
    end
    cycle(1, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h1000) begin
      errors++;
      $display("FAIL branch_target: got req=%b addr=%h expected 1/00001000", imem_bus.imem_req, imem_bus.imem_addr);
    end
    cycle(1, 0, 0, 0, 1, 32'hCCCC_1000);
    cycle(1, 0, 1, 32'h2000, 0, 0);
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_idle: got req=%b valid=%b expected 0/0", imem_bus.imem_req, id_valid);
    end
    cycle(1, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h2000) begin
      errors++;
      $display("FAIL branch_idle_target: got req=%b addr=%h expected 1/00002000", imem_bus.imem_req, imem_bus.imem_addr);
    end
    cycle(0, 0, 0, 0, 1, 32'hDDDD_2000);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_push_pop();
    pc_reg = 32'h300;
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 32'h1111_0300);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 32'h2222_0304);
    #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h304 || id_inst !== 32'h2222_0304) begin
      errors++;
      $display("FAIL push_pop_head: got valid=%b pc=%h inst=%h expected 1/304/22220304", id_valid, id_pc, id_inst);
    end
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 32'h3333_0308);
    cycle(1, 1, 0, 0, 0, 0);
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b0 || id_pc !== 32'h304) begin
      errors++;
      $display("FAIL full_hold: got req=%b pc=%h expected 0/304", imem_bus.imem_req, id_pc);
    end
    repeat (4) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_wait();
    pc_reg = 32'h400;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    rst = 1'b0;
    ce = 1'b0;
    imem_bus.imem_ack = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    pc_reg = 32'h40;
    cycle(1, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL post_reset_req: got req=%b addr=%h expected 1/00000040", imem_bus.imem_req, imem_bus.imem_addr);
    end
    cycle(0, 0, 0, 0, 1, 32'h4444_0040);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random(input int n);
    int mem_delay;
    bit prev_out;
    bit ack_v;
    mem_delay = 0;
    prev_out  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (m_out && !prev_out) mem_delay = $urandom_range(0, 3);
      prev_out = m_out;
      ack_v = 1'b0;
      if (m_out) begin
        if (mem_delay == 0) ack_v = 1'b1;
        else mem_delay--;
      end
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 14) == 0,
            $urandom & 32'hFFFF_FFFC, ack_v, $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_delayed_ack();
    test_stall_fill();
    test_branch();
    test_push_pop();
    test_reset_mid_wait();
    test_random(2000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
